// File: rtl/shift_out_ser.sv
// Parallel-to-serial feeder for the shift-in register: clear pulse, then MSB-first.
// Define SHIFT_OUT_HOLD_BUF_EN to add a one-entry holding buffer on the input.
module shift_out_ser #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_CLK,
  input  logic                  i_RST,
  input  logic [DATA_WIDTH-1:0] i_Data,
  input  logic                  i_Valid,
  output logic                  o_Ready,
  output logic                  o_CLR,
  output logic                  o_EN,
  output logic                  o_D,
  output logic                  o_Busy,
  output logic                  o_Done
);

  localparam int CW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    SHIFT,
    DONE
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [DATA_WIDTH-1:0] sr;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load;
  logic                  take_in;
  logic                  rdy;
  logic                  xfer;
  logic                  clr_s;
  logic                  en_s;
  logic                  d_s;
  logic                  done_s;

`ifdef SHIFT_OUT_HOLD_BUF_EN
  logic [DATA_WIDTH-1:0] hbuf;
  logic                  buf_full;
  logic                  push;
  logic                  pop;

  assign rdy = !buf_full;
`else
  assign rdy = (state == IDLE) || (state == DONE);
`endif

  // Reset forces every output low, even before the first edge.
  assign o_Ready = rdy && !i_RST;
  assign o_CLR   = clr_s && !i_RST;
  assign o_EN    = en_s && !i_RST;
  assign o_D     = d_s && !i_RST;
  assign o_Done  = done_s && !i_RST;
  assign o_Busy  = (state != IDLE) && !i_RST;
  assign xfer    = i_Valid && o_Ready;

  always_ff @(posedge i_CLK) begin
    if (i_RST) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    take_in   = 1'b0;
    load_data = i_Data;
    clr_s     = 1'b0;
    en_s      = 1'b0;
    d_s       = 1'b0;
    done_s    = 1'b0;
    unique case (state)
      IDLE: begin
        if (xfer) begin
          state_nxt = CLEAR;
          load      = 1'b1;
          take_in   = 1'b1;
        end
      end
      CLEAR: begin
        clr_s     = 1'b1;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        en_s = 1'b1;
        d_s  = sr[DATA_WIDTH-1];
        if (cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        done_s    = 1'b1;
        state_nxt = IDLE;
`ifdef SHIFT_OUT_HOLD_BUF_EN
        if (buf_full) begin
          state_nxt = CLEAR;
          load      = 1'b1;
          load_data = hbuf;
        end else if (xfer) begin
          state_nxt = CLEAR;
          load      = 1'b1;
          take_in   = 1'b1;
        end
`else
        if (xfer) begin
          state_nxt = CLEAR;
          load      = 1'b1;
          take_in   = 1'b1;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      sr  <= '0;
      cnt <= '0;
    end else begin
      if (load)                sr <= load_data;
      else if (state == SHIFT) sr <= sr << 1;
      if (state == CLEAR)
        cnt <= CW'(DATA_WIDTH - 1);
      else if (state == SHIFT && cnt != '0)
        cnt <= cnt - CW'(1);
    end
  end

`ifdef SHIFT_OUT_HOLD_BUF_EN
  // Words arriving while a word is in flight park here until DONE.
  assign push = xfer && !take_in;
  assign pop  = (state == DONE) && buf_full;

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      buf_full <= 1'b0;
      hbuf     <= '0;
    end else begin
      buf_full <= push || (buf_full && !pop);
      if (push) hbuf <= i_Data;
    end
  end
`else
  logic unused_take_in;
  assign unused_take_in = take_in;
`endif

endmodule

// File: tb/tb_shift_out_ser.sv
// Scoreboard bench for shift_out_ser with a downstream shift-in register model.
// Accepted words are queued; a monitor rebuilds each serial word and compares.
module tb_shift_out_ser;

  localparam int W = 32;

  logic         i_CLK = 1'b0;
  logic         i_RST = 1'b1;
  logic [W-1:0] i_Data = '0;
  logic         i_Valid = 1'b0;
  logic         o_Ready;
  logic         o_CLR;
  logic         o_EN;
  logic         o_D;
  logic         o_Busy;
  logic         o_Done;

  shift_out_ser #(.DATA_WIDTH(W)) dut (
    .i_CLK  (i_CLK),
    .i_RST  (i_RST),
    .i_Data (i_Data),
    .i_Valid(i_Valid),
    .o_Ready(o_Ready),
    .o_CLR  (o_CLR),
    .o_EN   (o_EN),
    .o_D    (o_D),
    .o_Busy (o_Busy),
    .o_Done (o_Done)
  );

  always #5 i_CLK = ~i_CLK;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  logic [W-1:0] exp_q[$];
  int           clr_q[$];
  int           done_q[$];
  int           cyc   = 0;
  int           ndone = 0;
  int           bits  = 0;
  logic [W:0]   ds    = '0;

  // Monitor: downstream register is cleared to a lone marker bit, then
  // shifts o_D in; after W shifts the marker sits in the top (WE) bit.
  always @(negedge i_CLK) begin
    logic [W-1:0] w;
    cyc++;
    if (i_RST) begin
      exp_q.delete();
      bits = 0;
      ds   = '0;
    end else begin
      chk("clr_en_excl", {63'd0, o_CLR & o_EN}, 64'd0);
      if (!o_EN) chk("d_low_no_en", {63'd0, o_D}, 64'd0);
      if (o_CLR | o_EN | o_Done) chk("busy", {63'd0, o_Busy}, 64'd1);
`ifndef SHIFT_OUT_HOLD_BUF_EN
      chk("ready", {63'd0, o_Ready}, {63'd0, !o_Busy || o_Done});
`endif
      if (o_CLR) begin
        ds   = {{W{1'b0}}, 1'b1};
        bits = 0;
        clr_q.push_back(cyc);
      end
      if (o_EN) begin
        ds = {ds[W-1:0], o_D};
        bits++;
      end
      if (o_Done) begin
        ndone++;
        done_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("done_unexpected", 64'd1, 64'd0);
        end else begin
          w = exp_q.pop_front();
          chk("word", {32'd0, ds[W-1:0]}, {32'd0, w});
          chk("we", {63'd0, ds[W]}, 64'd1);
          chk("bits", 64'(bits), 64'(W));
        end
      end
      if (i_Valid && o_Ready) exp_q.push_back(i_Data);
    end
  end

  task automatic send(input logic [W-1:0] d);
    int t = 0;
    i_Data  = d;
    i_Valid = 1'b1;
    @(negedge i_CLK);
    while (!o_Ready && t < 300) begin
      t++;
      @(negedge i_CLK);
    end
    if (t >= 300) chk("send_timeout", 64'd0, 64'd1);
    @(posedge i_CLK);
    #1;
  endtask

  task automatic idle(input int n);
    i_Valid = 1'b0;
    repeat (n) @(posedge i_CLK);
    #1;
  endtask

  task automatic wait_quiet();
    int t = 0;
    i_Valid = 1'b0;
    @(negedge i_CLK);
    while ((o_Busy || exp_q.size() != 0) && t < 500) begin
      t++;
      @(negedge i_CLK);
    end
    chk("drain_timeout", 64'(t < 500), 64'd1);
    @(posedge i_CLK);
    #1;
  endtask

  task automatic wait_en(input int n);
    int t = 0;
    int seen = 0;
    while (seen < n && t < 200) begin
      @(negedge i_CLK);
      if (o_EN) seen++;
      t++;
    end
    chk("en_timeout", 64'(seen), 64'(n));
  endtask

  logic [5:0] outs;
  assign outs = {o_Ready, o_CLR, o_EN, o_D, o_Busy, o_Done};

  initial begin
    int d0;
    int c0;
    logic [W-1:0] a;

    repeat (2) begin
      @(negedge i_CLK);
      chk("rst_outs", {58'd0, outs}, 64'd0);
    end
    @(posedge i_CLK);
    #1 i_RST = 1'b0;
    @(negedge i_CLK);
    chk("post_rst_ready", {63'd0, o_Ready}, 64'd1);
    chk("post_rst_busy", {63'd0, o_Busy}, 64'd0);
    @(posedge i_CLK);
    #1;

    d0 = ndone;
    send(32'd100);
    wait_quiet();
    chk("single_done", 64'(ndone - d0), 64'd1);

    clr_q.delete();
    done_q.delete();
    send(32'h0000_0000);
    send(32'hFFFF_FFFF);
    wait_quiet();
    chk("b2b_ndone", 64'(done_q.size()), 64'd2);
    if (done_q.size() == 2 && clr_q.size() == 2) begin
      chk("b2b_gap", 64'(clr_q[1] - done_q[0]), 64'd1);
      chk("b2b_total", 64'(done_q[1] - clr_q[0] + 1), 64'd68);
    end

    a = $urandom;
    send(a);
    i_Valid = 1'b0;
    wait_en(1);
    @(posedge i_CLK);
    #1;
    i_Data  = 32'd10498;
    i_Valid = 1'b1;
    @(negedge i_CLK);
`ifdef SHIFT_OUT_HOLD_BUF_EN
    chk("ready_in_shift", {63'd0, o_Ready}, 64'd1);
`else
    chk("ready_in_shift", {63'd0, o_Ready}, 64'd0);
`endif
    @(posedge i_CLK);
    #1;
    send(32'd10498);
    wait_quiet();

    send(32'd256);
    i_Valid = 1'b0;
    wait_en(10);
    @(posedge i_CLK);
    #1 i_RST = 1'b1;
    d0 = ndone;
    @(negedge i_CLK);
    chk("abort_outs0", {58'd0, outs}, 64'd0);
    @(posedge i_CLK);
    #1;
    @(negedge i_CLK);
    chk("abort_outs1", {58'd0, outs}, 64'd0);
    @(posedge i_CLK);
    #1 i_RST = 1'b0;
    idle(3);
    chk("abort_no_done", 64'(ndone), 64'(d0));
    chk("abort_idle", {63'd0, o_Busy}, 64'd0);
    send($urandom);
    wait_quiet();

`ifdef SHIFT_OUT_HOLD_BUF_EN
    send(32'd1);
    c0 = cyc;
    send(32'd2);
    chk("buf_no_stall", 64'(cyc - c0), 64'd1);
    i_Valid = 1'b0;
    @(negedge i_CLK);
    chk("buf_full_ready", {63'd0, o_Ready}, 64'd0);
    @(posedge i_CLK);
    #1;
    wait_quiet();
`else
    c0 = cyc;
    send(32'd1);
    send(32'd2);
    chk("nobuf_stall", 64'(cyc - c0 > 30), 64'd1);
    wait_quiet();
`endif

    repeat (40) begin
      send($urandom);
      if ($urandom_range(0, 2) != 0) idle($urandom_range(0, 40));
    end
    wait_quiet();
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
